// File: rtl/mux_scan_ctrl_pkg.sv
// Shared state encoding and default timing constants for the sensor-line mux scan controller.
package mux_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int DEF_SAMPLES       = 3;
   localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/mux_scan_ctrl_sample_voter.sv
// Majority voter: counts ones over a run of samples and reports the majority bit.
module mux_scan_ctrl_sample_voter
   import mux_scan_ctrl_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic sample_en,
   input  logic y_in,
   output logic vote
);

   localparam int OW = $clog2(SAMPLES + 1);

   logic [OW-1:0] ones_q;
   logic [OW-1:0] ones_d;
   logic [OW-1:0] ones_incl;

   // The vote includes the sample taken this cycle, so it is valid on the last sample edge.
   assign ones_incl = ones_q + OW'(y_in);
   assign vote      = ones_incl > OW'(SAMPLES / 2);

   always_comb begin
      ones_d = ones_q;
      if (clear) begin
         ones_d = '0;
      end else if (sample_en) begin
         ones_d = ones_incl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_q <= '0;
      end else begin
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 8:1 sensor-line mux: settle, vote, assemble a frame, hand it off.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int N_CH          = 8,
   parameter int SEL_W         = 3,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SAMPLES       = DEF_SAMPLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             single,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [N_CH-1:0]  frame,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic             busy,
   output logic             overrun
);

   scan_state_e      state_q;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N_CH-1:0]  scratch_q;
   logic [N_CH-1:0]  frame_q;
   logic             valid_q;
   logic             overrun_q;
   logic             vote;

   mux_scan_ctrl_sample_voter #(
      .SAMPLES(SAMPLES)
   ) u_sample_voter (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_q != SAMPLE),
      .sample_en(state_q == SAMPLE),
      .y_in     (y_in),
      .vote     (vote)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         scratch_q <= '0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         // Consumption is handled here outside DONE; DONE decides the holding register itself.
         if (state_q != DONE && valid_q && frame_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (en || single) begin
                  state_q <= SETTLE;
                  sel_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            SETTLE: begin
               if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state_q <= SAMPLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            SAMPLE: begin
               if (cnt_q == CNT_W'(SAMPLES - 1)) begin
                  scratch_q[sel_q] <= vote;
                  cnt_q            <= '0;
                  if (sel_q == SEL_W'(N_CH - 1)) begin
                     state_q <= DONE;
                  end else begin
                     sel_q   <= sel_q + SEL_W'(1);
                     state_q <= SETTLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (!valid_q) begin
                  frame_q <= scratch_q;
                  valid_q <= 1'b1;
               end else if (frame_ready) begin
                  frame_q <= scratch_q;
               end else begin
                  overrun_q <= 1'b1;
               end
               sel_q   <= '0;
               cnt_q   <= '0;
               state_q <= en ? SETTLE : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sel         = sel_q;
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign busy        = state_q != IDLE;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: mux model drives y_in, a timeline model predicts every output each cycle.
module tb_mux_scan_ctrl;

   localparam int N    = 8;
   localparam int SW   = 3;
   localparam int ST   = 4;
   localparam int SM   = 3;
   localparam int CH_T = ST + SM;
   localparam int SCAN = N * CH_T;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          single = 1'b0;
   logic          y_in = 1'b0;
   logic          frame_ready = 1'b0;
   logic [SW-1:0] sel;
   logic [N-1:0]  frame;
   logic          frame_valid;
   logic          busy;
   logic          overrun;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   logic [N-1:0] x = '0;
   int           force_ch = -1;
   logic [2:0]   force_mask = '0;

   bit           m_busy;
   int           m_k;
   int           m_sel;
   int           m_ones[N];
   logic [N-1:0] m_frame;
   bit           m_fv;
   bit           m_ov;

   mux_scan_ctrl #(
      .N_CH         (N),
      .SEL_W        (SW),
      .SETTLE_CYCLES(ST),
      .SAMPLES      (SM),
      .CNT_W        (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .single     (single),
      .y_in       (y_in),
      .sel        (sel),
      .frame      (frame),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_k     = 0;
      m_sel   = 0;
      m_frame = '0;
      m_fv    = 1'b0;
      m_ov    = 1'b0;
      foreach (m_ones[i]) m_ones[i] = 0;
   endtask

   // m_k is the index of the cycle within a scan: channel = m_k / CH_T, last cycle is the hand-off.
   task automatic model_step();
      int ch;
      int off;
      logic [N-1:0] v;
      m_ov = 1'b0;
      if (!m_busy) begin
         if (m_fv && frame_ready) m_fv = 1'b0;
         if (en || single) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_sel  = 0;
            foreach (m_ones[i]) m_ones[i] = 0;
         end
      end else if (m_k < SCAN) begin
         if (m_fv && frame_ready) m_fv = 1'b0;
         ch  = m_k / CH_T;
         off = m_k % CH_T;
         if (off >= ST) m_ones[ch] += (y_in === 1'b1) ? 1 : 0;
         if (off == CH_T - 1 && ch < N - 1) m_sel = ch + 1;
         m_k++;
      end else begin
         for (int i = 0; i < N; i++) v[i] = (m_ones[i] * 2 > SM);
         if (!m_fv) begin
            m_frame = v;
            m_fv    = 1'b1;
         end else if (frame_ready) begin
            m_frame = v;
         end else begin
            m_ov = 1'b1;
         end
         m_sel = 0;
         if (en) begin
            m_k = 0;
            foreach (m_ones[i]) m_ones[i] = 0;
         end else begin
            m_busy = 1'b0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // External mux: y_in follows the DUT select, with optional forced-zero samples on one channel.
   initial begin
      int off;
      forever begin
         @(negedge clk);
         y_in = x[sel];
         if (m_busy && m_k < SCAN && (m_k / CH_T) == force_ch) begin
            off = (m_k % CH_T) - ST;
            if (off >= 0 && force_mask[off]) y_in = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on && !rst) begin
         check("sel", 32'(sel), 32'(m_sel));
         check("frame", 32'(frame), 32'(m_frame));
         check("frame_valid", 32'(frame_valid), 32'(m_fv));
         check("busy", 32'(busy), 32'(m_busy));
         check("overrun", 32'(overrun), 32'(m_ov));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      en          = 1'b0;
      single      = 1'b0;
      frame_ready = 1'b0;
      force_ch    = -1;
      force_mask  = '0;
      rst         = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_sel", 32'(sel), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame_valid", 32'(frame_valid), 0);
      check("rst_frame", 32'(frame), 0);
      check("rst_overrun", 32'(overrun), 0);
      rst    = 1'b0;
      chk_on = 1'b1;
   endtask

   task automatic start_en();
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rise(input string name, input int exp_edges);
      int   n;
      bit   seen;
      logic prev;
      n    = 0;
      seen = 1'b0;
      prev = frame_valid;
      while (n < 200 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (frame_valid === 1'b1 && prev !== 1'b1) seen = 1'b1;
         prev = frame_valid;
      end
      check(name, 32'(n), 32'(exp_edges));
   endtask

   initial begin
      // Back-to-back scans with a consumer always ready.
      do_reset();
      x           = 8'hA5;
      frame_ready = 1'b1;
      start_en();
      wait_rise("s1_latency", 57);
      check("s1_frame", 32'(frame), 32'h0A5);
      x = 8'h5A;
      wait_rise("s1_b2b_latency", 57);
      check("s1_b2b_frame", 32'(frame), 32'h05A);

      // Majority vote on channel 3: one bad sample tolerated, two flip the bit.
      do_reset();
      x           = 8'hFF;
      frame_ready = 1'b1;
      force_ch    = 3;
      force_mask  = 3'b010;
      start_en();
      wait_rise("s2_latency", 57);
      check("s2_frame_1bad", 32'(frame), 32'h0FF);
      force_mask = 3'b011;
      wait_rise("s2_latency2", 57);
      check("s2_frame_2bad", 32'(frame), 32'h0F7);

      // Consumer stalled: second frame dropped with a one-cycle overrun.
      do_reset();
      x = 8'h3C;
      start_en();
      wait_rise("s3_latency", 57);
      check("s3_frame", 32'(frame), 32'h03C);
      x = 8'hC3;
      repeat (57) @(posedge clk);
      #1;
      check("s3_overrun_pulse", 32'(overrun), 1);
      check("s3_frame_kept", 32'(frame), 32'h03C);
      check("s3_valid_kept", 32'(frame_valid), 1);
      @(posedge clk);
      #1;
      check("s3_overrun_end", 32'(overrun), 0);
      check("s3_valid_still", 32'(frame_valid), 1);

      // Ready asserted only on the hand-off cycle of scan 2.
      do_reset();
      x = 8'h3C;
      start_en();
      wait_rise("s4_latency", 57);
      x = 8'hC3;
      repeat (56) @(posedge clk);
      @(negedge clk);
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      check("s4_frame_new", 32'(frame), 32'h0C3);
      check("s4_valid", 32'(frame_valid), 1);
      check("s4_no_overrun", 32'(overrun), 0);
      @(negedge clk);
      frame_ready = 1'b0;

      // One-shot scan; a second single while busy is ignored.
      do_reset();
      x           = 8'h81;
      frame_ready = 1'b1;
      @(negedge clk);
      single = 1'b1;
      @(posedge clk);
      #1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      single = 1'b1;
      @(negedge clk);
      single = 1'b0;
      wait_rise("s5_latency", 47);
      check("s5_frame", 32'(frame), 32'h081);
      check("s5_idle_busy", 32'(busy), 0);
      check("s5_idle_sel", 32'(sel), 0);
      repeat (20) @(posedge clk);
      #1;
      check("s5_still_idle", 32'(busy), 0);
      check("s5_consumed", 32'(frame_valid), 0);

      // Asynchronous reset mid-scan, then a fresh scan from channel 0.
      do_reset();
      x = 8'h5A;
      start_en();
      wait_rise("s6_latency", 57);
      check("s6_frame", 32'(frame), 32'h05A);
      x = 8'h96;
      repeat (20) @(posedge clk);
      #1;
      check("s6_sel_pre", 32'(sel), 2);
      #2;
      rst = 1'b1;
      #1;
      check("s6_rst_sel", 32'(sel), 0);
      check("s6_rst_busy", 32'(busy), 0);
      check("s6_rst_valid", 32'(frame_valid), 0);
      check("s6_rst_frame", 32'(frame), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("s6_restart_sel", 32'(sel), 0);
      wait_rise("s6_restart_latency", 57);
      check("s6_restart_frame", 32'(frame), 32'h096);

      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
